// File: rtl/parity_word_tx.sv
// -----------------------------------------------------------------------------
// parity_word_tx
//
// Transmit side of the parity-protected word link. Words arrive from the
// producer over a valid/ready handshake, get one parity bit attached at push
// time, and are handed to the link through a 2-entry first-in first-out
// buffer. The link-side checker accepts a word when
// (^out_data ^ out_parity) == 0 for even parity.
//
// Parameters
//   WIDTH    data word width in bits (>= 1)
//   ODD_PAR  0: out_parity = ^out_data (even), 1: out_parity = ~^out_data (odd)
//   CNT_W    width of the delivered-word counter
//
// Ports
//   clk         in   1      single clock, everything on posedge
//   rst         in   1      asynchronous assert, active-high reset
//   in_valid    in   1      producer word valid
//   in_ready    out  1      a word can be accepted this cycle (registered)
//   in_data     in   WIDTH  producer word
//   out_valid   out  1      link word valid
//   out_ready   in   1      link consumes the word this cycle
//   out_data    out  WIDTH  head word of the buffer (registered)
//   out_parity  out  1      parity stored with the head word (registered)
//   tx_count    out  CNT_W  words delivered on the link, wraps to 0
//   inj_err     in   1      only when PARITY_ERR_INJ_EN is defined
//
// Build option
//   PARITY_ERR_INJ_EN  when defined, adds the inj_err port. A pulse arms a
//                      sticky flag; the next pushed word (or a word pushed in
//                      the same cycle as the pulse) is stored with inverted
//                      parity, after which the flag clears. When undefined
//                      the port and flag do not exist and parity is always
//                      correct.
//
// Structure
//   The buffer is a head register pair (data + parity) driving the outputs
//   directly, plus a tail register pair used only when two words are held.
//   There is no combinational path from the producer side to the link side.
// -----------------------------------------------------------------------------
module parity_word_tx #(
    parameter int WIDTH   = 32,
    parameter bit ODD_PAR = 1'b0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic [CNT_W-1:0] tx_count
`ifdef PARITY_ERR_INJ_EN
    ,
    input  logic             inj_err
`endif
);

    // Buffer occupancy encoded as a small state machine.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       occ_q,       occ_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic             head_par_q,  head_par_d;
    logic [WIDTH-1:0] tail_data_q, tail_data_d;
    logic             tail_par_q,  tail_par_d;
    logic             in_ready_q,  in_ready_d;
    logic [CNT_W-1:0] tx_count_q,  tx_count_d;

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    logic push;
    logic pop;
    logic head_valid;

    assign head_valid = (occ_q != OCC_EMPTY);
    assign push       = in_valid & in_ready_q;
    assign pop        = head_valid & out_ready;

    // -------------------------------------------------------------------------
    // Parity generation and optional error injection
    // -------------------------------------------------------------------------
    logic inj_now;      // invert parity of the word pushed this cycle
    logic push_par;     // parity bit stored alongside in_data

`ifdef PARITY_ERR_INJ_EN
    logic inj_flag_q, inj_flag_d;

    // A pulse coinciding with a push corrupts that push directly, so the
    // flag only needs to remember pulses that arrive while nothing is pushed.
    assign inj_now = inj_flag_q | inj_err;

    always_comb begin
        inj_flag_d = inj_flag_q;
        if (push) begin
            inj_flag_d = 1'b0;
        end else if (inj_err) begin
            inj_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_flag_q <= 1'b0;
        end else begin
            inj_flag_q <= inj_flag_d;
        end
    end
`else
    assign inj_now = 1'b0;
`endif

    // Even parity is the XOR reduction; odd parity is its complement.
    assign push_par = (^in_data) ^ ODD_PAR ^ inj_now;

    // -------------------------------------------------------------------------
    // Buffer next-state logic
    //
    // The head pair only changes when a word enters an empty buffer or when
    // the current head is consumed, which keeps out_data/out_parity frozen
    // while the link stalls.
    // -------------------------------------------------------------------------
    always_comb begin
        occ_d       = occ_q;
        head_data_d = head_data_q;
        head_par_d  = head_par_q;
        tail_data_d = tail_data_q;
        tail_par_d  = tail_par_q;

        case (occ_q)
            OCC_EMPTY: begin
                // No bypass: the word appears on the outputs next cycle.
                if (push) begin
                    head_data_d = in_data;
                    head_par_d  = push_par;
                    occ_d       = OCC_ONE;
                end
            end

            OCC_ONE: begin
                case ({push, pop})
                    2'b10: begin
                        tail_data_d = in_data;
                        tail_par_d  = push_par;
                        occ_d       = OCC_FULL;
                    end
                    2'b01: begin
                        occ_d = OCC_EMPTY;
                    end
                    2'b11: begin
                        // Head leaves and the new word takes its place,
                        // which is what sustains one word per cycle.
                        head_data_d = in_data;
                        head_par_d  = push_par;
                    end
                    default: begin
                        occ_d = OCC_ONE;
                    end
                endcase
            end

            OCC_FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    head_data_d = tail_data_q;
                    head_par_d  = tail_par_q;
                    occ_d       = OCC_ONE;
                end
            end

            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
    end

    // in_ready is registered from the next occupancy so the producer sees a
    // clean flop output.
    assign in_ready_d = (occ_d != OCC_FULL);

    // Delivered-word counter wraps naturally at 2^CNT_W.
    assign tx_count_d = pop ? (tx_count_q + CNT_W'(1)) : tx_count_q;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q       <= OCC_EMPTY;
            head_data_q <= '0;
            head_par_q  <= 1'b0;
            tail_data_q <= '0;
            tail_par_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            tx_count_q  <= '0;
        end else begin
            occ_q       <= occ_d;
            head_data_q <= head_data_d;
            head_par_q  <= head_par_d;
            tail_data_q <= tail_data_d;
            tail_par_q  <= tail_par_d;
            in_ready_q  <= in_ready_d;
            tx_count_q  <= tx_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready   = in_ready_q;
    assign out_valid  = head_valid;
    assign out_data   = head_data_q;
    assign out_parity = head_par_q;
    assign tx_count   = tx_count_q;

    // -------------------------------------------------------------------------
    // Link-side protocol properties
    // -------------------------------------------------------------------------
    a_valid_held: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> out_valid);

    a_word_held: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_parity)));

endmodule

// File: tb/tb_parity_word_tx.sv
module tb_parity_word_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_parity;
    logic [15:0] tx_count;
    logic        inj_err = 1'b0;

    // Odd-parity instance shares all inputs with the main instance.
    logic        o_in_ready;
    logic        o_out_valid;
    logic [31:0] o_out_data;
    logic        o_out_parity;
    logic [15:0] o_tx_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parity_word_tx #(.WIDTH(32), .ODD_PAR(1'b0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_parity(out_parity), .tx_count(tx_count)
`ifdef PARITY_ERR_INJ_EN
        , .inj_err(inj_err)
`endif
    );

    parity_word_tx #(.WIDTH(32), .ODD_PAR(1'b1), .CNT_W(16)) dut_odd (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(o_in_ready), .in_data(in_data),
        .out_valid(o_out_valid), .out_ready(out_ready),
        .out_data(o_out_data), .out_parity(o_out_parity), .tx_count(o_tx_count)
`ifdef PARITY_ERR_INJ_EN
        , .inj_err(1'b0)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inj_err   = 1'b0;
        rst       = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_checks++; if (out_parity !== 1'b0) begin n_fail++; $display("FAIL reset_out_parity: got %b expected 0", out_parity); end
        n_checks++; if (tx_count !== 16'h0) begin n_fail++; $display("FAIL reset_tx_count: got %h expected 0", tx_count); end
        rst = 1'b0;
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after: got %b expected 1", in_ready); end
        $display("test_reset: done");
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0001;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_data !== 32'h0000_0001) begin n_fail++; $display("FAIL single_data: got %h expected 00000001", out_data); end
        n_checks++; if (out_parity !== 1'b1) begin n_fail++; $display("FAIL single_parity: got %b expected 1", out_parity); end
        n_checks++; if (tx_count !== 16'd0) begin n_fail++; $display("FAIL single_count_before: got %0d expected 0", tx_count); end
        step();
        n_checks++; if (tx_count !== 16'd1) begin n_fail++; $display("FAIL single_count_after: got %0d expected 1", tx_count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b expected 0", out_valid); end
        out_ready = 1'b0;
        $display("test_single: word 00000001 delivered, tx_count=%0d", tx_count);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hFFFF_FFFF;
        step();
        in_data = 32'h0000_0003;
        step();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b expected 0", in_ready); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", out_valid); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_stall_data: got %h expected ffffffff", out_data); end
            n_checks++; if (out_parity !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_parity: got %b expected 0", out_parity); end
            step();
        end
        out_ready = 1'b1;
        step();
        $display("b2b: second word on link data=%h parity=%b", out_data, out_parity);
        n_checks++; if (out_data !== 32'h0000_0003) begin n_fail++; $display("FAIL b2b_second_data: got %h expected 00000003", out_data); end
        n_checks++; if (out_parity !== 1'b0) begin n_fail++; $display("FAIL b2b_second_parity: got %b expected 0", out_parity); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_back: got %b expected 1", in_ready); end
        n_checks++; if (tx_count !== 16'd2) begin n_fail++; $display("FAIL b2b_count_mid: got %0d expected 2", tx_count); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b expected 0", out_valid); end
        n_checks++; if (tx_count !== 16'd3) begin n_fail++; $display("FAIL b2b_count_end: got %0d expected 3", tx_count); end
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] words [100];
        logic [31:0] exp_q [$];
        logic [31:0] exp_w;
        int sent = 0;
        int recv = 0;
        int first_pop = -1;
        int last_pop = -1;
        int stalls = 0;
        do_reset();
        for (int i = 0; i < 100; i++) words[i] = $urandom;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && recv < 100; cyc++) begin
            in_valid = (sent < 100);
            in_data  = (sent < 100) ? words[sent] : 32'h0;
            if (out_valid && out_ready) begin
                exp_w = exp_q.pop_front();
                $display("stream pop %0d: data=%h parity=%b", recv, out_data, out_parity);
                n_checks++; if (out_data !== exp_w) begin n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", recv, out_data, exp_w); end
                n_checks++; if (out_parity !== (^exp_w)) begin n_fail++; $display("FAIL stream_parity[%0d]: got %b expected %b", recv, out_parity, ^exp_w); end
                n_checks++; if (o_out_parity !== ~(^exp_w)) begin n_fail++; $display("FAIL stream_odd_parity[%0d]: got %b expected %b", recv, o_out_parity, ~(^exp_w)); end
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                recv++;
            end
            if (in_valid && !in_ready) stalls++;
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                sent++;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (recv !== 100) begin n_fail++; $display("FAIL stream_recv_count: got %0d expected 100", recv); end
        n_checks++; if (last_pop - first_pop !== 99) begin n_fail++; $display("FAIL stream_throughput: got span %0d expected 99", last_pop - first_pop); end
        n_checks++; if (stalls !== 0) begin n_fail++; $display("FAIL stream_stalls: got %0d expected 0", stalls); end
        n_checks++; if (tx_count !== 16'd100) begin n_fail++; $display("FAIL stream_tx_count: got %0d expected 100", tx_count); end
    endtask

    task automatic test_odd_parity();
        do_reset();
        in_valid = 1'b1;
        in_data  = 32'h0000_0000;
        step();
        in_valid = 1'b0;
        $display("odd: word 00000000 odd_parity=%b even_parity=%b", o_out_parity, out_parity);
        n_checks++; if (o_out_valid !== 1'b1) begin n_fail++; $display("FAIL odd_valid: got %b expected 1", o_out_valid); end
        n_checks++; if (o_out_parity !== 1'b1) begin n_fail++; $display("FAIL odd_parity_zero: got %b expected 1", o_out_parity); end
        n_checks++; if (out_parity !== 1'b0) begin n_fail++; $display("FAIL even_parity_zero: got %b expected 0", out_parity); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        int pushes = 0;
        int pops = 0;
        do_reset();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 70000 && pops < 65535; cyc++) begin
            in_valid = (pushes < 65535);
            in_data  = pushes;
            if (out_valid && out_ready) pops++;
            if (in_valid && in_ready) pushes++;
            step();
        end
        in_valid = 1'b0;
        $display("wrap: %0d pops, tx_count=%h", pops, tx_count);
        n_checks++; if (tx_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ffff", tx_count); end
        in_valid = 1'b1;
        in_data  = 32'h0000_0005;
        step();
        in_valid = 1'b0;
        step();
        n_checks++; if (tx_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_to_zero: got %h expected 0000", tx_count); end
        in_valid = 1'b1;
        in_data  = 32'h0000_0007;
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        step();
        in_data = 32'h9ABC_DEF0;
        step();
        in_valid = 1'b0;
        n_checks++; if (tx_count !== 16'd1) begin n_fail++; $display("FAIL midrst_pre_count: got %0d expected 1", tx_count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_full: got %b expected 0", in_ready); end
        #2;
        rst = 1'b1;
        #1;
        $display("mid-transfer reset: out_valid=%b tx_count=%0d", out_valid, tx_count);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
        n_checks++; if (tx_count !== 16'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", tx_count); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL midrst_data: got %h expected 0", out_data); end
        step();
        rst = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_discarded: got %b expected 0", out_valid); end
    endtask

`ifdef PARITY_ERR_INJ_EN
    task automatic test_inject();
        do_reset();
        inj_err = 1'b1;
        step();
        inj_err   = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0001;
        step();
        $display("inject: armed word parity=%b", out_parity);
        n_checks++; if (out_parity !== 1'b0) begin n_fail++; $display("FAIL inj_corrupt: got %b expected 0", out_parity); end
        step();
        $display("inject: following word parity=%b", out_parity);
        n_checks++; if (out_data !== 32'h0000_0001) begin n_fail++; $display("FAIL inj_next_data: got %h expected 00000001", out_data); end
        n_checks++; if (out_parity !== 1'b1) begin n_fail++; $display("FAIL inj_next_clean: got %b expected 1", out_parity); end
        in_data = 32'h0000_0002;
        inj_err = 1'b1;
        step();
        inj_err = 1'b0;
        n_checks++; if (out_parity !== 1'b0) begin n_fail++; $display("FAIL inj_same_cycle: got %b expected 0", out_parity); end
        step();
        in_valid = 1'b0;
        n_checks++; if (out_parity !== 1'b1) begin n_fail++; $display("FAIL inj_same_cycle_clear: got %b expected 1", out_parity); end
        step();
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stream();
        test_odd_parity();
        test_wrap_and_reset();
`ifdef PARITY_ERR_INJ_EN
        test_inject();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
